// File: rtl/div_sequencer.sv
// div_sequencer: issues DIV/DIVU to the iterative divider and owns the HI/LO registers.
// Ports:
//   clock, reset_n                 - clock, async active-low reset
//   op_valid, op_signed, op_a/b    - division request from EX
//   flush                          - squash the in-flight division
//   mthi, mtlo, mt_data            - direct HI/LO writes (IDLE only)
//   hi, lo                         - architectural HI (remainder) / LO (quotient)
//   stall, done, err_timeout       - pipeline freeze, commit pulse, sticky watchdog flag
//   div_start, div_signed,
//   div_dividend, div_divisor      - launch and operands to the divider
//   div_busy, div_q, div_r         - divider status and results
module div_sequencer #(
  parameter int TIMEOUT = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        done,
  output logic        err_timeout,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_ZERO   = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic          sgn_q, sgn_d, rise_q, rise_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, counting, expire;

  always_comb begin
    accept   = (state_q == S_IDLE) && op_valid && !flush;
    counting = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    expire   = counting && (cnt_q == CW'(TIMEOUT - 1));
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = accept ? op_a : a_q;
    b_d      = accept ? op_b : b_q;
    sgn_d    = accept ? op_signed : sgn_q;
    rise_d   = accept ? 1'b0 : rise_q;
    cnt_d    = accept ? '0 : counting ? cnt_q + CW'(1) : cnt_q;
    err_d    = err_q || expire;
    case (state_q)
      S_IDLE: begin
        hi_d    = mthi ? mt_data : hi_q;
        lo_d    = mtlo ? mt_data : lo_q;
        state_d = !accept ? S_IDLE : (op_b == 32'd0) ? S_ZERO : S_ISSUE;
      end
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT:  state_d = flush ? S_DRAIN : div_busy ? S_RUN : S_WAIT;
      S_RUN: begin
        // busy has already been seen high, so DRAIN only has to wait for the fall
        rise_d  = flush ? 1'b1 : rise_q;
        state_d = flush ? S_DRAIN : div_busy ? S_RUN : S_COMMIT;
      end
      S_COMMIT: begin
        lo_d    = div_q;
        hi_d    = div_r;
        state_d = S_IDLE;
      end
      S_ZERO: begin
        lo_d    = 32'hFFFF_FFFF;
        hi_d    = a_q;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        rise_d  = rise_q || div_busy;
        state_d = (rise_q && !div_busy) ? S_IDLE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
    state_d = expire ? S_IDLE : state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rise_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rise_q  <= rise_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign stall        = (state_q != S_IDLE) || (op_valid && !flush);
  assign done         = (state_q == S_COMMIT) || (state_q == S_ZERO);
  assign err_timeout  = err_q;
  assign div_start    = (state_q == S_ISSUE);
  assign div_signed   = sgn_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed bench for div_sequencer with a behavioural divider model.
module tb_div_sequencer;
  localparam int N = 32;
  localparam int TO = 48;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        op_valid = 1'b0, op_signed = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, mt_data = '0;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        stall, done, err_timeout, div_start, div_signed;
  logic        div_busy = 1'b0;
  logic [31:0] div_q = '0, div_r = '0;
  logic        hang = 1'b0;
  int          bcnt = 0;
  int          total = 0, bad = 0;
  int          st_cyc, starts, dones;

  div_sequencer #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .hi(hi), .lo(lo), .stall(stall), .done(done), .err_timeout(err_timeout),
    .div_start(div_start), .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;

  // Divider: samples start on the falling edge, stays busy N+1 falling edges.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_busy <= 1'b0;
      bcnt     <= 0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      bcnt     <= N;
      div_q    <= div_signed ? 32'($signed(div_dividend) / $signed(div_divisor)) : div_dividend / div_divisor;
      div_r    <= div_signed ? 32'($signed(div_dividend) % $signed(div_divisor)) : div_dividend % div_divisor;
    end else if (div_busy && !hang) begin
      if (bcnt == 0) div_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: presents the op, lets it be accepted, then counts
  // stall cycles until the first IDLE cycle (left at that falling edge).
  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_signed = sg; op_a = a; op_b = b;
    @(posedge clock); #1;
    op_valid = 1'b0;
    st_cyc = 0; starts = 0; dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!stall) break;
      st_cyc++;
      starts += int'(div_start);
      dones  += int'(done);
    end
  endtask

  initial begin
    #2;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_start", {31'd0, div_start}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    check("rst_stall0", {31'd0, stall}, 32'd0);
    op_valid = 1'b1; #1;
    check("rst_stall1", {31'd0, stall}, 32'd1);
    op_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(1'b1, 32'd100, 32'd7);
    check("div1_stall", st_cyc, N + 3);
    check("div1_start", starts, 32'd1);
    check("div1_done", dones, 32'd1);
    check("div1_sgn", {31'd0, div_signed}, 32'd1);
    check("div1_lo", lo, 32'd14);
    check("div1_hi", hi, 32'd2);

    do_op(1'b1, -32'sd100, 32'd7);
    check("div2_lo", lo, 32'hFFFF_FFF2);
    check("div2_hi", hi, 32'hFFFF_FFFE);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2);
    check("divu_sgn", {31'd0, div_signed}, 32'd0);
    check("divu_dvd", div_dividend, 32'hFFFF_FFFF);
    check("divu_lo", lo, 32'h7FFF_FFFF);
    check("divu_hi", hi, 32'd1);
    check("divu_done", dones, 32'd1);

    do_op(1'b0, 32'd1234, 32'd0);
    check("zero_stall", st_cyc, 32'd1);
    check("zero_start", starts, 32'd0);
    check("zero_done", dones, 32'd1);
    check("zero_lo", lo, 32'hFFFF_FFFF);
    check("zero_hi", hi, 32'd1234);

    mthi = 1'b1; mt_data = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    mthi = 1'b0;
    check("mthi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, 32'hFFFF_FFFF);
    @(negedge clock);

    op_valid = 1'b1; op_signed = 1'b1; op_a = 32'd50; op_b = 32'd5;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (12) @(negedge clock);
    flush = 1'b1; mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
    @(negedge clock);
    flush = 1'b0; mtlo = 1'b0;
    st_cyc = 0; dones = 0;
    for (int i = 0; i < 200; i++) begin
      if (!stall) break;
      st_cyc++;
      dones += int'(done);
      @(negedge clock);
    end
    check("flush_stall", st_cyc, 32'd22);
    check("flush_done", dones, 32'd0);
    check("flush_busy", {31'd0, div_busy}, 32'd0);
    check("flush_lo", lo, 32'hFFFF_FFFF);
    check("flush_hi", hi, 32'hA5A5_A5A5);

    do_op(1'b1, 32'd50, 32'd5);
    check("after_lo", lo, 32'd10);
    check("after_hi", hi, 32'd0);
    check("after_done", dones, 32'd1);

    hang = 1'b1;
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd9; op_b = 32'd3;
    @(posedge clock); #1;
    op_valid = 1'b0;
    st_cyc = 0; dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (err_timeout) break;
      st_cyc++;
      dones += int'(done);
    end
    check("to_cycles", st_cyc, TO);
    check("to_err", {31'd0, err_timeout}, 32'd1);
    check("to_idle", {31'd0, stall}, 32'd0);
    check("to_done", dones, 32'd0);
    check("to_lo", lo, 32'd10);
    check("to_hi", hi, 32'd0);
    repeat (5) @(negedge clock);
    check("to_sticky", {31'd0, err_timeout}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
